// File: rtl/uart_sched_pkg.sv
// Shared types and sizing helpers for the UART transmit scheduler.
package uart_sched_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } sched_state_e;

    localparam int BURST_W = 8;

    // A single requester index still needs one bit, so the width never drops to zero.
    function automatic int gid_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Requester-side and transmitter-side signals of the scheduler, grouped as one bundle.
// Requester handshake: req[i] with data/last is held until ack[i] pulses; the next byte may follow one cycle later.
interface uart_tx_scheduler_if
    import uart_sched_pkg::*;
#(
    parameter int N_REQ = 4
);
    localparam int GW = gid_width(N_REQ);

    logic [N_REQ-1:0]   req;
    logic [8*N_REQ-1:0] data;
    logic [N_REQ-1:0]   last;
    logic [N_REQ-1:0]   ack;
    logic               tx_data_valid;
    logic [7:0]         tx_data;
    logic               tx_busy;
    logic [GW-1:0]      grant_id;
    logic               active;

    modport master (
        output req, data, last, tx_busy,
        input  ack, tx_data_valid, tx_data, grant_id, active
    );

    modport slave (
        input  req, data, last, tx_busy,
        output ack, tx_data_valid, tx_data, grant_id, active
    );

endinterface

// File: rtl/uart_rr_arbiter.sv
// Rotating-priority picker: the first asserted request at or after ptr, wrapping modulo N_REQ.
module uart_rr_arbiter
    import uart_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    localparam int GW   = gid_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [GW-1:0]    ptr,
    output logic [GW-1:0]    winner,
    output logic             found
);

    logic [GW-1:0] idx;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = GW'((int'(ptr) + i) % N_REQ);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin, frame-locked sharing of one UART transmitter among N_REQ byte streams.
// Every output is a register; a byte is launched on the edge that enters ISSUE.
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    uart_tx_scheduler_if.slave bus,
    output sched_state_e       state
);

    localparam int GW = gid_width(N_REQ);
    localparam logic [BURST_W-1:0] BURST_LIMIT = BURST_W'(MAX_BURST);
    localparam logic [GW-1:0]      LAST_ID     = GW'(N_REQ - 1);

    sched_state_e       state_q, state_d;
    logic [GW-1:0]      ptr_q, ptr_d, grant_q, grant_d, winner, sel;
    logic               found, issue;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic               last_q, last_d, active_q, active_d, valid_q, valid_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic [7:0]         data_q, data_d;

    uart_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req    (bus.req),
        .ptr    (ptr_q),
        .winner (winner),
        .found  (found)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            grant_q  <= '0;
            burst_q  <= '0;
            last_q   <= 1'b0;
            active_q <= 1'b0;
            valid_q  <= 1'b0;
            ack_q    <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            burst_q  <= burst_d;
            last_q   <= last_d;
            active_q <= active_d;
            valid_q  <= valid_d;
            ack_q    <= ack_d;
            data_q   <= data_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        burst_d  = burst_q;
        last_d   = last_q;
        active_d = active_q;
        valid_d  = 1'b0;
        ack_d    = '0;
        data_d   = data_q;
        issue    = 1'b0;
        sel      = grant_q;

        if (!en) begin
            // Abort: drop the grant but keep the pointer so fairness is preserved.
            state_d  = IDLE;
            active_d = 1'b0;
            burst_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!bus.tx_busy && found) begin
                        grant_d  = winner;
                        active_d = 1'b1;
                        burst_d  = '0;
                        sel      = winner;
                        issue    = 1'b1;
                        state_d  = ISSUE;
                    end
                end
                ISSUE: begin
                    burst_d = (burst_q == '1) ? burst_q : burst_q + BURST_W'(1);
                    state_d = WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (bus.tx_busy) state_d = WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (!bus.tx_busy) begin
                        if (!last_q && (burst_q < BURST_LIMIT) && bus.req[grant_q]) begin
                            issue   = 1'b1;
                            state_d = ISSUE;
                        end else begin
                            active_d = 1'b0;
                            ptr_d    = (grant_q == LAST_ID) ? '0 : grant_q + GW'(1);
                            state_d  = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Byte, its end-of-frame flag and the ack are all taken on the edge entering ISSUE.
        if (issue) begin
            valid_d    = 1'b1;
            ack_d[sel] = 1'b1;
            data_d     = bus.data[int'(sel)*8 +: 8];
            last_d     = bus.last[sel];
        end
    end

    assign bus.ack           = ack_q;
    assign bus.tx_data_valid = valid_q;
    assign bus.tx_data       = data_q;
    assign bus.grant_id      = grant_q;
    assign bus.active        = active_q;
    assign state             = state_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: per-requester byte queues, a busy-timer transmitter and a frame-level model.
module tb_uart_tx_scheduler;
    import uart_sched_pkg::*;

    localparam int N_REQ     = 4;
    localparam int MAX_BURST = 4;
    localparam int BUSY_LEN  = 10;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    sched_state_e state;

    uart_tx_scheduler_if #(.N_REQ(N_REQ)) bus ();

    uart_tx_scheduler #(.N_REQ(N_REQ), .MAX_BURST(MAX_BURST)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .bus   (bus.slave),
        .state (state)
    );

    always #5 clk = ~clk;

    // Source queues: bit 8 is the end-of-frame flag, bits 7:0 the byte.
    logic [8:0] src_q [N_REQ][$];
    int         src_log[$];
    int         passed = 0, total = 0, cyc = 0;
    int         busy_cnt = 0, busy_fall_cyc = -100;
    int         m_cur = -1, m_cnt = 0, m_ptr = 0, m_gnt = 0;
    bit         m_last = 1'b0;
    int         n_valid = 0, first_issue_cyc = -1, first_gap = -1;
    int         ack_cnt[N_REQ];
    bit         prev_active = 1'b0, abort_flag = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic drive_req();
        for (int i = 0; i < N_REQ; i++) begin
            logic [8:0] h;
            h = (src_q[i].size() != 0) ? src_q[i][0] : 9'h000;
            bus.req[i]         = (src_q[i].size() != 0);
            bus.data[8*i +: 8] = h[7:0];
            bus.last[i]        = h[8];
        end
    endtask

    task automatic push(input int r, input logic [8:0] v);
        src_q[r].push_back(v);
        drive_req();
    endtask

    // Frame-level prediction of which requester owns the next byte.
    task automatic model_next(output int e, output bit cont);
        cont = 1'b0;
        if (m_cur >= 0 && !m_last && m_cnt < MAX_BURST && src_q[m_cur].size() != 0) begin
            e    = m_cur;
            cont = 1'b1;
            return;
        end
        if (m_cur >= 0) m_ptr = (m_cur + 1) % N_REQ;
        e = -1;
        for (int k = 0; k < N_REQ; k++) begin
            int idx;
            idx = (m_ptr + k) % N_REQ;
            if (e < 0 && src_q[idx].size() != 0) e = idx;
        end
        m_cur = e;
        m_cnt = 0;
    endtask

    task automatic monitor();
        if (bus.tx_data_valid || bus.ack != '0) begin
            int         e;
            bit         cont;
            logic [8:0] h;
            model_next(e, cont);
            check("valid_with_ack", 32'(bus.tx_data_valid), 1);
            check("tx_idle_at_issue", busy_cnt, 0);
            if (e < 0) begin
                check("unexpected_issue", 32'(bus.ack), 0);
            end else begin
                h = src_q[e][0];
                check("ack_onehot", 32'(bus.ack), 32'(1) << e);
                check("tx_data", 32'(bus.tx_data), 32'(h[7:0]));
                check("grant_id", 32'(bus.grant_id), e);
                check("active_at_issue", 32'(bus.active), 1);
                if (cont) check("byte_gap", cyc - busy_fall_cyc, 1);
                m_cnt++;
                m_last = h[8];
                m_gnt  = e;
                void'(src_q[e].pop_front());
                ack_cnt[e]++;
                src_log.push_back(e);
            end
            n_valid++;
            if (first_issue_cyc < 0) begin
                first_issue_cyc = cyc;
                first_gap       = cyc - busy_fall_cyc;
            end
        end
        if (prev_active && !bus.active) begin
            if (!abort_flag) check("release_latency", cyc - busy_fall_cyc, 1);
            abort_flag = 1'b0;
        end
        prev_active = bus.active;
    endtask

    task automatic tx_step();
        if (busy_cnt > 0) busy_cnt--;
        if (bus.tx_data_valid) busy_cnt = BUSY_LEN;
        if (bus.tx_busy && busy_cnt == 0) busy_fall_cyc = cyc;
        bus.tx_busy = (busy_cnt != 0);
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        monitor();
        tx_step();
        drive_req();
    endtask

    task automatic clear_stats();
        n_valid = 0;
        first_issue_cyc = -1;
        src_log.delete();
        for (int i = 0; i < N_REQ; i++) ack_cnt[i] = 0;
    endtask

    function automatic bit pending();
        for (int i = 0; i < N_REQ; i++) if (src_q[i].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic wait_state(input string tag, input sched_state_e s);
        int k = 0;
        while (k < 200 && state != s) begin
            step();
            k++;
        end
        check(tag, 32'(state), 32'(s));
    endtask

    task automatic settle(input string tag);
        int k = 0;
        while (k < 3000 && (pending() || bus.active || busy_cnt != 0 || state != IDLE)) begin
            step();
            k++;
        end
        check(tag, 32'(k < 3000), 1);
        if (m_cur >= 0) m_ptr = (m_cur + 1) % N_REQ;
        m_cur = -1;
        check({tag, "_grant_hold"}, 32'(bus.grant_id), m_gnt);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        int push_cyc;
        bus.req = '0;
        bus.data = '0;
        bus.last = '0;
        bus.tx_busy = 1'b0;
        clear_stats();

        repeat (3) step();
        check("rst_valid", 32'(bus.tx_data_valid), 0);
        check("rst_ack", 32'(bus.ack), 0);
        check("rst_tx_data", 32'(bus.tx_data), 0);
        check("rst_grant_id", 32'(bus.grant_id), 0);
        check("rst_active", 32'(bus.active), 0);
        check("rst_state", 32'(state), 32'(IDLE));
        rst_n = 1'b1;
        en = 1'b1;
        repeat (2) step();

        // Single three-byte frame from requester 0.
        clear_stats();
        push(0, 9'h041);
        push(0, 9'h042);
        push(0, 9'h143);
        push_cyc = cyc;
        settle("sf_settle");
        check("sf_valid_cnt", n_valid, 3);
        check("sf_ack0_cnt", ack_cnt[0], 3);
        check("sf_start_latency", first_issue_cyc - push_cyc, 1);
        check("sf_active_low", 32'(bus.active), 0);

        // Requesters 0 and 2 with back-to-back one-byte frames.
        clear_stats();
        for (int k = 0; k < 4; k++) begin
            push(0, {1'b1, 8'($urandom_range(0, 255))});
            push(2, {1'b1, 8'($urandom_range(0, 255))});
        end
        settle("rr_settle");
        check("rr_valid_cnt", n_valid, 8);
        check("rr_ack1_cnt", ack_cnt[1], 0);
        check("rr_first", src_log[0], 2);
        for (int j = 1; j < src_log.size(); j++)
            check("rr_alternate", src_log[j], (src_log[j-1] == 0) ? 2 : 0);

        // Requester 1 streams past the burst limit while requester 3 waits.
        clear_stats();
        for (int k = 0; k < 10; k++) push(1, {1'b0, 8'($urandom_range(0, 255))});
        push(3, {1'b0, 8'($urandom_range(0, 255))});
        push(3, {1'b1, 8'($urandom_range(0, 255))});
        settle("burst_settle");
        check("burst_valid_cnt", n_valid, 12);
        check("burst_first_run_end", src_log[3], 1);
        check("burst_handover", src_log[4], 3);
        check("burst_resume", src_log[6], 1);

        // Requester 0 stops presenting bytes mid-frame.
        clear_stats();
        push(0, {1'b0, 8'($urandom_range(0, 255))});
        push(0, {1'b0, 8'($urandom_range(0, 255))});
        settle("drop_settle");
        check("drop_valid_cnt", n_valid, 2);
        check("drop_ack0_cnt", ack_cnt[0], 2);

        // Enable drops in WAIT_DONE and returns while the transmitter is still busy.
        clear_stats();
        push(2, {1'b0, 8'($urandom_range(0, 255))});
        push(2, {1'b0, 8'($urandom_range(0, 255))});
        push(2, {1'b1, 8'($urandom_range(0, 255))});
        wait_state("abort_reach_wait_done", WAIT_DONE);
        en = 1'b0;
        abort_flag = 1'b1;
        m_cur = -1;
        step();
        check("abort_active", 32'(bus.active), 0);
        check("abort_state", 32'(state), 32'(IDLE));
        check("abort_valid", 32'(bus.tx_data_valid), 0);
        check("abort_ack", 32'(bus.ack), 0);
        repeat (2) step();
        en = 1'b1;
        first_issue_cyc = -1;
        settle("abort_settle");
        check("abort_restart_gap", first_gap, 1);
        check("abort_ack2_cnt", ack_cnt[2], 3);

        // Asynchronous reset while a byte is in flight.
        clear_stats();
        push(3, {1'b0, 8'($urandom_range(0, 255))});
        push(3, {1'b1, 8'($urandom_range(0, 255))});
        wait_state("rst_reach_wait_busy", WAIT_BUSY);
        abort_flag = 1'b1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.tx_data_valid), 0);
        check("mid_rst_ack", 32'(bus.ack), 0);
        check("mid_rst_tx_data", 32'(bus.tx_data), 0);
        check("mid_rst_grant_id", 32'(bus.grant_id), 0);
        check("mid_rst_active", 32'(bus.active), 0);
        check("mid_rst_state", 32'(state), 32'(IDLE));
        m_ptr = 0;
        m_cur = -1;
        push(1, {1'b1, 8'($urandom_range(0, 255))});
        repeat (2) step();
        rst_n = 1'b1;
        src_log.delete();
        settle("rst_settle");
        check("rst_ptr_first", src_log[0], 1);
        check("rst_then_3", src_log[1], 3);

        // Random loads on all requesters.
        for (int round = 0; round < 6; round++) begin
            for (int r = 0; r < N_REQ; r++) begin
                int n;
                n = $urandom_range(0, 6);
                for (int b = 0; b < n; b++)
                    push(r, {(b == n - 1) ? 1'b1 : 1'($urandom_range(0, 3) == 0),
                             8'($urandom_range(0, 255))});
            end
            settle("rand_settle");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
